frame_descrambler32: RTL and testbench

//  Receive-side descrambler for the 32-bit word link. Hunts for an unscrambled

---
 rtl/frame_descrambler32_pkg.sv | 22 ++
 rtl/frame_descrambler32_xor32.sv | 11 +
 rtl/frame_descrambler32.sv | 106 ++++++++++
 tb/tb_frame_descrambler32.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_descrambler32_pkg.sv
// Shared types and defaults for the 32-bit frame descrambler.
// Holds the hunt/run state type, the default link constants and the
// Galois LFSR step used to generate the keystream.
package descr_pkg;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] DEF_SEED      = 32'hFFFF_FFFF;
    localparam logic [31:0] DEF_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] DEF_SYNC_WORD = 32'hA5A5_5A5A;
    localparam logic [15:0] DEF_FRAME_LEN = 16'd256;

    // One Galois step: shift left, fold the taps in when the MSB falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                              input logic [31:0] poly);
        return {state[30:0], 1'b0} ^ (state[31] ? poly : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/frame_descrambler32_xor32.sv
// Plain 32-bit XOR gate, used to combine payload words with the keystream.
module xor32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    // Bitwise combine; no state.
    assign y = a ^ b;

endmodule

// File: rtl/frame_descrambler32.sv
// Receive-side descrambler for the 32-bit word link.
// Hunts for an unscrambled sync marker, then XORs FRAME_LEN payload words
// with a Galois-LFSR keystream and re-hunts. Output is a one-entry register.
// Optional feature macro: DESCR_SYNC_ERRCNT_EN (saturating count of words
// dropped while hunting; when undefined sync_err_cnt is tied to zero).
//
// Handshake: a word moves on any cycle where valid and ready are both 1.
// Upstream may not rely on in_ready before presenting in_valid; downstream
// sees out_data/out_last held stable while out_valid=1 and out_ready=0.
module frame_descrambler32
    import descr_pkg::*;
#(
    parameter logic [31:0] SEED      = DEF_SEED,
    parameter logic [31:0] POLY      = DEF_POLY,
    parameter logic [31:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter logic [15:0] FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        in_sync,
    output logic [7:0]  sync_err_cnt
);

    state_t      state;
    logic [31:0] lfsr;
    logic [15:0] word_cnt;
    logic [31:0] plain;
    logic        accept;
    logic        payload_accept;
    logic        sync_accept;
    logic        last_word;

    // Keystream combine for the word currently on the input.
    xor32 u_xor (
        .a (in_data),
        .b (lfsr),
        .y (plain)
    );

    // While hunting every word is taken; in RUN the output register gates input.
    assign in_ready       = (state == SYNC) ? 1'b1 : (!out_valid || out_ready);
    assign accept         = in_valid && in_ready;
    assign payload_accept = accept && (state == RUN);
    assign sync_accept    = accept && (state == SYNC);
    assign last_word      = (word_cnt == FRAME_LEN - 16'd1);
    assign in_sync        = (state == RUN);

    // FSM, keystream, word counter and output register in one place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SYNC;
            lfsr      <= SEED;
            word_cnt  <= 16'd0;
            out_valid <= 1'b0;
            out_data  <= 32'h0000_0000;
            out_last  <= 1'b0;
        end else begin
            // A drain with no replacement empties the register.
            if (out_valid && out_ready && !payload_accept) begin
                out_valid <= 1'b0;
            end
            if (sync_accept && (in_data == SYNC_WORD)) begin
                lfsr     <= SEED;
                word_cnt <= 16'd0;
                state    <= RUN;
            end
            if (payload_accept) begin
                out_data  <= plain;
                out_valid <= 1'b1;
                out_last  <= last_word;
                lfsr      <= lfsr_next(lfsr, POLY);
                if (last_word) begin
                    word_cnt <= 16'd0;
                    state    <= SYNC;
                end else begin
                    word_cnt <= word_cnt + 16'd1;
                end
            end
        end
    end

`ifdef DESCR_SYNC_ERRCNT_EN
    logic [7:0] err_cnt;

    // Count words thrown away while hunting, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (sync_accept && (in_data != SYNC_WORD) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end

    assign sync_err_cnt = err_cnt;
`else
    assign sync_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_frame_descrambler32.sv
// Directed bench for frame_descrambler32: a FRAME_LEN=2 instance (a) for the
// short-frame cases and a default FRAME_LEN=256 instance (b) for streaming.
module tb_frame_descrambler32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid_a, in_valid_b;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_last_a, in_sync_a;
    logic [31:0] out_data_a;
    logic [7:0]  sync_err_cnt_a;
    logic        in_ready_b, out_valid_b, out_last_b, in_sync_b;
    logic [31:0] out_data_b;
    logic [7:0]  sync_err_cnt_b;

    frame_descrambler32 #(.FRAME_LEN(16'd2)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid_a),
        .in_ready     (in_ready_a),
        .in_data      (in_data),
        .out_valid    (out_valid_a),
        .out_ready    (out_ready),
        .out_data     (out_data_a),
        .out_last     (out_last_a),
        .in_sync      (in_sync_a),
        .sync_err_cnt (sync_err_cnt_a)
    );

    frame_descrambler32 dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid_b),
        .in_ready     (in_ready_b),
        .in_data      (in_data),
        .out_valid    (out_valid_b),
        .out_ready    (out_ready),
        .out_data     (out_data_b),
        .out_last     (out_last_b),
        .in_sync      (in_sync_b),
        .sync_err_cnt (sync_err_cnt_b)
    );

    int errors = 0;
    int checks = 0;
    int stalls = 0;

`ifdef DESCR_SYNC_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] got_a[$];
    logic [31:0] got_b[$];
    logic        last_a[$];
    logic        last_b[$];
    time         t_b[$];

    // Output transfers are recorded mid-cycle; the handshake completes at the next edge.
    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready) begin
            got_a.push_back(out_data_a);
            last_a.push_back(out_last_a);
        end
        if (rst_n && out_valid_b && out_ready) begin
            got_b.push_back(out_data_b);
            last_b.push_back(out_last_b);
            t_b.push_back($time);
        end
    end

    function automatic logic [31:0] model_next(input logic [31:0] s);
        logic [31:0] r;
        r = s << 1;
        if (s[31]) r = r ^ 32'h04C1_1DB7;
        return r;
    endfunction

    function automatic logic [7:0] exp_err(input int n);
        if (!ERRCNT_ON) return 8'h00;
        if (n > 255) return 8'hFF;
        return n[7:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input bit sel, input logic [31:0] d);
        bit acc;
        int n;
        in_data = d;
        if (sel) in_valid_b = 1'b1;
        else     in_valid_a = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = sel ? in_ready_b : in_ready_a;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        if (n > 1) stalls += n - 1;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=0 after %0d cycles, wanted 1", n);
        end
    endtask

    task automatic clear_q();
        got_a.delete(); last_a.delete();
        got_b.delete(); last_b.delete(); t_b.delete();
        exp_q.delete();
        stalls = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_q();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid_a = 0; in_valid_b = 0; in_data = 0; out_ready = 1;
        #12;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_a); end
        checks++; if (out_data_a !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 00000000", out_data_a); end
        checks++; if (out_last_a !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last_a); end
        checks++; if (in_sync_a !== 1'b0) begin errors++; $display("FAIL reset_in_sync got %b want 0", in_sync_a); end
        checks++; if (sync_err_cnt_a !== 8'h00) begin errors++; $display("FAIL reset_err_cnt got %h want 00", sync_err_cnt_a); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        // Mid-stream reset with a held output word
        out_ready = 1'b0;
        send(0, 32'hA5A5_5A5A);
        send(0, 32'hFFFF_FFFF);
        checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL midreset_held got %b want 1", out_valid_a); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b want 0", out_valid_a); end
        checks++; if (in_sync_a !== 1'b0) begin errors++; $display("FAIL midreset_in_sync got %b want 0", in_sync_a); end
        checks++; if (sync_err_cnt_a !== 8'h00) begin errors++; $display("FAIL midreset_err_cnt got %h want 00", sync_err_cnt_a); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        clear_q();
        // Without a fresh marker a payload-like word is dropped
        send(0, 32'hFFFF_FFFF);
        idle(3);
        checks++; if (got_a.size() != 0) begin errors++; $display("FAIL postreset_no_output got %0d words want 0", got_a.size()); end
        checks++; if (in_sync_a !== 1'b0) begin errors++; $display("FAIL postreset_in_sync got %b want 0", in_sync_a); end
    endtask

    task automatic test_basic();
        pulse_reset();
        send(0, 32'hA5A5_5A5A);
        send(0, 32'hFFFF_FFFF);
        send(0, 32'hFB3E_E249);
        idle(3);
        checks++; if (got_a.size() != 2) begin errors++; $display("FAIL basic_count got %0d want 2", got_a.size()); end
        if (got_a.size() == 2) begin
            checks++; if (got_a[0] !== 32'h0) begin errors++; $display("FAIL basic_w0 got %h want 00000000", got_a[0]); end
            checks++; if (got_a[1] !== 32'h0) begin errors++; $display("FAIL basic_w1 got %h want 00000000", got_a[1]); end
            checks++; if (last_a[0] !== 1'b0) begin errors++; $display("FAIL basic_last0 got %b want 0", last_a[0]); end
            checks++; if (last_a[1] !== 1'b1) begin errors++; $display("FAIL basic_last1 got %b want 1", last_a[1]); end
        end
        checks++; if (in_sync_a !== 1'b0) begin errors++; $display("FAIL basic_in_sync got %b want 0", in_sync_a); end
    endtask

    task automatic test_hunt();
        pulse_reset();
        send(0, 32'h1234_5678);
        send(0, 32'h0000_0000);
        send(0, 32'hA5A5_5A5A);
        send(0, 32'hFFFF_FFFF);
        idle(3);
        checks++; if (got_a.size() != 1) begin errors++; $display("FAIL hunt_count got %0d want 1", got_a.size()); end
        if (got_a.size() == 1) begin
            checks++; if (got_a[0] !== 32'h0) begin errors++; $display("FAIL hunt_w0 got %h want 00000000", got_a[0]); end
            checks++; if (last_a[0] !== 1'b0) begin errors++; $display("FAIL hunt_last0 got %b want 0", last_a[0]); end
        end
        checks++; if (sync_err_cnt_a !== exp_err(2)) begin errors++; $display("FAIL hunt_err_cnt got %h want %h", sync_err_cnt_a, exp_err(2)); end
        checks++; if (in_sync_a !== 1'b1) begin errors++; $display("FAIL hunt_in_sync got %b want 1", in_sync_a); end
        // Sync word inside a frame is plain data: A5A55A5A ^ FB3EE249 = 5E9BB813
        send(0, 32'hA5A5_5A5A);
        idle(3);
        checks++; if (got_a.size() != 2) begin errors++; $display("FAIL hunt_data_sync_count got %0d want 2", got_a.size()); end
        if (got_a.size() == 2) begin
            checks++; if (got_a[1] !== 32'h5E9B_B813) begin errors++; $display("FAIL hunt_data_sync got %h want 5e9bb813", got_a[1]); end
            checks++; if (last_a[1] !== 1'b1) begin errors++; $display("FAIL hunt_last1 got %b want 1", last_a[1]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] lfsr;
        logic [31:0] held;
        pulse_reset();
        lfsr = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] d;
            d = 32'h1000_0000 + i * 32'h0101_0101;
            exp_q.push_back(d ^ lfsr);
            lfsr = model_next(lfsr);
        end
        fork
            begin
                send(1, 32'hA5A5_5A5A);
                for (int i = 0; i < 10; i++) send(1, 32'h1000_0000 + i * 32'h0101_0101);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held = out_data_b;
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    checks++; if (out_valid_b !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d got %b want 1", k, out_valid_b); end
                    checks++; if (out_data_b !== held) begin errors++; $display("FAIL bp_stable cyc%0d got %h want %h", k, out_data_b, held); end
                    checks++; if (in_ready_b !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got %b want 0", k, in_ready_b); end
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(3);
        checks++; if (got_b.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", got_b.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
            checks++; if (got_b[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, got_b[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] lfsr;
        int nlast;
        pulse_reset();
        lfsr = 32'hFFFF_FFFF;
        send(1, 32'hA5A5_5A5A);
        for (int i = 0; i < 256; i++) begin
            logic [31:0] d;
            d = 32'hDEAD_0000 ^ (i * 32'h0001_0003);
            exp_q.push_back(d ^ lfsr);
            lfsr = model_next(lfsr);
            send(1, d);
        end
        checks++; if (in_sync_b !== 1'b0) begin errors++; $display("FAIL tp_in_sync_after got %b want 0", in_sync_b); end
        idle(3);
        checks++; if (stalls != 0) begin errors++; $display("FAIL tp_stalls got %0d want 0", stalls); end
        checks++; if (got_b.size() != 256) begin errors++; $display("FAIL tp_count got %0d want 256", got_b.size()); end
        if (got_b.size() == 256) begin
            checks++; if (t_b[255] - t_b[0] != 2550) begin errors++; $display("FAIL tp_rate got %0t want 2550", t_b[255] - t_b[0]); end
            nlast = 0;
            for (int i = 0; i < 256; i++) begin
                if (last_b[i]) nlast++;
                checks++; if (got_b[i] !== exp_q[i]) begin errors++; $display("FAIL tp_word%0d got %h want %h", i, got_b[i], exp_q[i]); end
            end
            checks++; if (last_b[255] !== 1'b1) begin errors++; $display("FAIL tp_last_final got %b want 1", last_b[255]); end
            checks++; if (nlast != 1) begin errors++; $display("FAIL tp_last_count got %0d want 1", nlast); end
        end
        send(1, 32'hA5A5_5A5A);
        idle(2);
        checks++; if (in_sync_b !== 1'b1) begin errors++; $display("FAIL tp_resync got %b want 1", in_sync_b); end
        checks++; if (got_b.size() != 256) begin errors++; $display("FAIL tp_sync_not_output got %0d want 256", got_b.size()); end
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int i = 0; i < 300; i++) begin
            send(0, 32'h0000_0001 + i);
            if (i == 253) begin
                checks++; if (sync_err_cnt_a !== exp_err(254)) begin errors++; $display("FAIL sat_254 got %h want %h", sync_err_cnt_a, exp_err(254)); end
            end
            if (i == 254) begin
                checks++; if (sync_err_cnt_a !== exp_err(255)) begin errors++; $display("FAIL sat_255 got %h want %h", sync_err_cnt_a, exp_err(255)); end
            end
        end
        idle(2);
        checks++; if (sync_err_cnt_a !== exp_err(300)) begin errors++; $display("FAIL sat_final got %h want %h", sync_err_cnt_a, exp_err(300)); end
        checks++; if (got_a.size() != 0) begin errors++; $display("FAIL sat_no_output got %0d want 0", got_a.size()); end
        checks++; if (in_sync_a !== 1'b0) begin errors++; $display("FAIL sat_in_sync got %b want 0", in_sync_a); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_hunt();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
